// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with show-ahead option and sticky error flags
module sync_fifo_param #(
    parameter int WIDTH     = 48,
    parameter int DEPTH     = 256,
    parameter int AF_LEVEL  = DEPTH - 4,
    parameter int AE_LEVEL  = 4,
    parameter int SHOWAHEAD = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     sclr,
    input  logic [WIDTH-1:0]         data,
    input  logic                     write_req,
    input  logic                     read_req,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0]  used_nxt;
    logic              rd_acc;
    logic              wr_acc;
    logic [WIDTH-1:0]  q_nxt;
    logic              q_load;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_acc = read_req && !empty;
    assign wr_acc = write_req && (!full || rd_acc);

    always_comb begin
        wr_ptr_nxt = wr_acc ? wr_ptr + ADDR_W'(1) : wr_ptr;
        rd_ptr_nxt = rd_acc ? rd_ptr + ADDR_W'(1) : rd_ptr;
        used_nxt   = used;
        case ({wr_acc, rd_acc})
            2'b10:   used_nxt = used + CNT_W'(1);
            2'b01:   used_nxt = used - CNT_W'(1);
            default: used_nxt = used;
        endcase
    end

    // Show-ahead keeps q on the next head; a word written into that slot this
    // edge is not in mem yet, so it is forwarded straight from data.
    always_comb begin
        q_nxt  = mem[rd_ptr];
        q_load = rd_acc;
        if (SHOWAHEAD != 0) begin
            q_load = 1'b1;
            if (wr_acc && (wr_ptr == rd_ptr_nxt))
                q_nxt = data;
            else
                q_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc && !sclr)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            used         <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            q            <= '0;
        end else if (sclr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            used         <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            q            <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            used         <= used_nxt;
            empty        <= (used_nxt == '0);
            full         <= (used_nxt == DEPTH_C);
            almost_empty <= (used_nxt <= AE_C);
            almost_full  <= (used_nxt >= AF_C);
            if (q_load)
                q <= q_nxt;
            if (write_req && !wr_acc)
                overflow <= 1'b1;
            if (read_req && !rd_acc)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       sclr;
    logic [7:0] data;
    logic       write_req;
    logic       read_req;

    logic [7:0] a_q, s_q, w_q;
    logic       a_empty, a_full, a_ae, a_af, a_ov, a_un;
    logic       s_empty, s_full, s_ae, s_af, s_ov, s_un;
    logic       w_empty, w_full, w_ae, w_af, w_ov, w_un;
    logic [3:0] a_used, s_used;
    logic [2:0] w_used;

    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .SHOWAHEAD(0)) u_a (
        .CLK(clk), .RESET_N(rst_n), .sclr(sclr), .data(data), .write_req(write_req),
        .read_req(read_req), .q(a_q), .empty(a_empty), .full(a_full), .almost_empty(a_ae),
        .almost_full(a_af), .used(a_used), .overflow(a_ov), .underflow(a_un));

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .SHOWAHEAD(1)) u_s (
        .CLK(clk), .RESET_N(rst_n), .sclr(sclr), .data(data), .write_req(write_req),
        .read_req(read_req), .q(s_q), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
        .almost_full(s_af), .used(s_used), .overflow(s_ov), .underflow(s_un));

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .SHOWAHEAD(0)) u_w (
        .CLK(clk), .RESET_N(rst_n), .sclr(sclr), .data(data), .write_req(write_req),
        .read_req(read_req), .q(w_q), .empty(w_empty), .full(w_full), .almost_empty(w_ae),
        .almost_full(w_af), .used(w_used), .overflow(w_ov), .underflow(w_un));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_req = 1'b0;
        read_req  = 1'b0;
        sclr      = 1'b0;
    endtask

    task automatic do_sclr();
        idle();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] d;

    initial begin
        rst_n = 1'b0;
        data  = '0;
        idle();
        tick();
        tick();
        check("rst_used", 32'(a_used), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_ae", 32'(a_ae), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_af", 32'(a_af), 0);
        check("rst_ov", 32'(a_ov), 0);
        check("rst_un", 32'(a_un), 0);
        check("rst_q", 32'(a_q), 0);
        rst_n = 1'b1;
        tick();

        // fill 1..8 then drain
        for (int i = 1; i <= 8; i++) begin
            data = 8'(i);
            write_req = 1'b1;
            tick();
            check("fill_used", 32'(a_used), 32'(i));
            check("fill_ae", 32'(a_ae), (i <= 1) ? 1 : 0);
            check("fill_af", 32'(a_af), (i >= 6) ? 1 : 0);
            check("fill_full", 32'(a_full), (i == 8) ? 1 : 0);
        end
        idle();
        for (int i = 1; i <= 8; i++) begin
            read_req = 1'b1;
            tick();
            check("drain_q", 32'(a_q), 32'(i));
        end
        idle();
        check("drain_empty", 32'(a_empty), 1);
        check("drain_ov", 32'(a_ov), 0);
        check("drain_un", 32'(a_un), 0);

        // overflow / underflow
        do_sclr();
        for (int i = 0; i < 9; i++) begin
            data = 8'(8'h30 + i);
            write_req = 1'b1;
            tick();
        end
        idle();
        check("ovf_used", 32'(a_used), 8);
        check("ovf_flag", 32'(a_ov), 1);
        for (int i = 0; i < 8; i++) begin
            read_req = 1'b1;
            tick();
            check("ovf_rd_q", 32'(a_q), 32'(8'h30 + i));
        end
        check("ovf_empty", 32'(a_empty), 1);
        read_req = 1'b1;
        tick();
        idle();
        check("unf_flag", 32'(a_un), 1);
        check("unf_q_hold", 32'(a_q), 32'h37);
        do_sclr();
        check("sclr_ov", 32'(a_ov), 0);
        check("sclr_un", 32'(a_un), 0);
        check("sclr_used", 32'(a_used), 0);
        check("sclr_empty", 32'(a_empty), 1);
        check("sclr_q", 32'(a_q), 0);

        // simultaneous read+write when full, then when empty
        for (int i = 0; i < 8; i++) begin
            data = 8'(8'h40 + i);
            write_req = 1'b1;
            tick();
        end
        data = 8'hAA;
        write_req = 1'b1;
        read_req  = 1'b1;
        tick();
        idle();
        check("simf_used", 32'(a_used), 8);
        check("simf_full", 32'(a_full), 1);
        check("simf_ov", 32'(a_ov), 0);
        check("simf_q", 32'(a_q), 32'h40);
        for (int i = 1; i <= 8; i++) begin
            read_req = 1'b1;
            tick();
            check("simf_rd_q", 32'(a_q), (i == 8) ? 32'hAA : 32'(8'h40 + i));
        end
        idle();
        data = 8'h55;
        write_req = 1'b1;
        read_req  = 1'b1;
        tick();
        idle();
        check("sime_used", 32'(a_used), 1);
        check("sime_un", 32'(a_un), 1);
        check("sime_q_hold", 32'(a_q), 32'hAA);

        // show-ahead
        do_sclr();
        data = 8'h11;
        write_req = 1'b1;
        tick();
        idle();
        check("sa_first_q", 32'(s_q), 32'h11);
        data = 8'h22;
        write_req = 1'b1;
        tick();
        idle();
        check("sa_hold_q", 32'(s_q), 32'h11);
        check("sa_used2", 32'(s_used), 2);
        read_req = 1'b1;
        tick();
        idle();
        check("sa_next_q", 32'(s_q), 32'h22);
        check("sa_used1", 32'(s_used), 1);
        read_req = 1'b1;
        tick();
        idle();
        check("sa_empty", 32'(s_empty), 1);
        check("sa_un", 32'(s_un), 0);

        // wrap-around on DEPTH=4
        do_sclr();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            data = d;
            exp_q.push_back(d);
            write_req = 1'b1;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            data = d;
            write_req = 1'b1;
            read_req  = 1'b1;
            tick();
            check("wrap_q", 32'(w_q), 32'(exp_q.pop_front()));
            exp_q.push_back(d);
        end
        idle();
        check("wrap_used", 32'(w_used), 2);
        for (int i = 0; i < 2; i++) begin
            read_req = 1'b1;
            tick();
            check("wrap_tail_q", 32'(w_q), 32'(exp_q.pop_front()));
        end
        idle();
        check("wrap_empty", 32'(w_empty), 1);
        check("wrap_ov", 32'(w_ov), 0);

        // async reset between edges
        do_sclr();
        for (int i = 0; i < 5; i++) begin
            data = 8'(8'h60 + i);
            write_req = 1'b1;
            tick();
        end
        idle();
        data = 8'h99;
        write_req = 1'b1;
        read_req  = 1'b1;
        tick();
        idle();
        check("ar_pre_used", 32'(a_used), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_used", 32'(a_used), 0);
        check("ar_empty", 32'(a_empty), 1);
        check("ar_ae", 32'(a_ae), 1);
        check("ar_af", 32'(a_af), 0);
        check("ar_ov", 32'(a_ov), 0);
        check("ar_q", 32'(a_q), 0);
        #2;
        rst_n = 1'b1;
        data = 8'h77;
        write_req = 1'b1;
        tick();
        idle();
        check("ar_resume_used", 32'(a_used), 1);
        read_req = 1'b1;
        tick();
        idle();
        check("ar_resume_q", 32'(a_q), 32'h77);
        check("ar_resume_empty", 32'(a_empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
